muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative multiply / divide unit for a pipelined CPU's HiLo register.
// One operation runs at a time through IDLE -> PREP -> RUN (WIDTH cycles)
// -> FIX -> WRITE. A divide by zero skips straight from PREP to WRITE.
//   multiply : shift-add, one multiplier bit per RUN cycle
//   divide   : restoring division, one quotient bit per RUN cycle
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   - Signed=1 treats A/B as two's complement (magnitudes in PREP,
//               sign correction in FIX)
//   undefined - Signed is ignored, every operation is unsigned, FIX passes
//               the result through (still one cycle, so latency is the same)
//
// Ports
//   Clk        : clock, rising edge
//   Rst        : asynchronous active-low reset
//   Start      : operation request, accepted in IDLE only
//   Op         : 0 = multiply, 1 = divide (captured with Start)
//   Signed     : two's-complement operands (captured with Start)
//   A, B       : multiplicand/dividend and multiplier/divisor
//   Busy       : state is not IDLE
//   Stall      : (Start in IDLE) or Busy, holds the program counter
//   HiLoEn     : one-cycle HiLo write strobe (WRITE state)
//   HiLoWrite  : {Hi, Lo}; mul = full product, div = {remainder, quotient}
//   Done       : same cycle as HiLoEn
//   DivByZero  : with Done when a divide had B = 0
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic                 Op,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic                 Stall,
    output logic                 HiLoEn,
    output logic [2*WIDTH-1:0]   HiLoWrite,
    output logic                 Done,
    output logic                 DivByZero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FIX   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    logic [2:0]           state_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 op_reg;
    logic                 sgn_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     m_reg;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     hi_reg;     // product high half / partial remainder
    logic [WIDTH-1:0]     lo_reg;     // multiplier bits / dividend-then-quotient
    logic                 neg_q_reg;  // product or quotient must be negated
    logic                 neg_r_reg;  // remainder must be negated
    logic                 dbz_reg;
    logic [2*WIDTH-1:0]   result_reg;

`ifndef MULDIV_SIGNED_EN
    // Signed has no effect in the unsigned-only build.
    logic unused_signed;
    assign unused_signed = Signed;
`endif

    // Operand magnitudes; sgn_reg is constant 0 in the unsigned-only build.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = sgn_reg & a_reg[WIDTH-1];
    assign b_neg = sgn_reg & b_reg[WIDTH-1];
    assign a_mag = a_neg ? -a_reg : a_reg;
    assign b_mag = b_neg ? -b_reg : b_reg;

    // One shift-add multiply step: add the multiplicand when the current
    // multiplier bit is set, then shift {carry, hi, lo} right by one.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, m_reg} : {(WIDTH+1){1'b0}});

    // One restoring-divide step. The partial remainder is always below the
    // divisor, so the shifted value is below 2*divisor and the top bit of the
    // difference is a clean "borrow" (shifted < divisor) indicator.
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ge;
    assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_reg};
    assign div_ge    = ~div_diff[WIDTH];

    // Sign correction applied in FIX.
    logic [2*WIDTH-1:0] prod_raw, prod_fix, fix_result;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_raw   = {hi_reg, lo_reg};
    assign prod_fix   = neg_q_reg ? -prod_raw : prod_raw;
    assign quo_fix    = neg_q_reg ? -lo_reg : lo_reg;
    assign rem_fix    = neg_r_reg ? -hi_reg : hi_reg;
    assign fix_result = op_reg ? {rem_fix, quo_fix} : prod_fix;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            op_reg     <= 1'b0;
            sgn_reg    <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            m_reg      <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            dbz_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (Start) begin
                        op_reg    <= Op;
`ifdef MULDIV_SIGNED_EN
                        sgn_reg   <= Signed;
`else
                        sgn_reg   <= 1'b0;
`endif
                        a_reg     <= A;
                        b_reg     <= B;
                        dbz_reg   <= 1'b0;
                        state_reg <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_q_reg <= a_neg ^ b_neg;
                    neg_r_reg <= a_neg;
                    cnt_reg   <= CW'(WIDTH);
                    hi_reg    <= '0;
                    if (op_reg) begin
                        lo_reg <= a_mag;
                        m_reg  <= b_mag;
                        if (b_reg == '0) begin
                            // Divide by zero: Hi keeps the raw dividend.
                            result_reg <= {a_reg, {WIDTH{1'b1}}};
                            dbz_reg    <= 1'b1;
                            state_reg  <= S_WRITE;
                        end else begin
                            state_reg  <= S_RUN;
                        end
                    end else begin
                        lo_reg    <= b_mag;
                        m_reg     <= a_mag;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    if (op_reg) begin
                        hi_reg <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        lo_reg <= {lo_reg[WIDTH-2:0], div_ge};
                    end else begin
                        hi_reg <= mul_sum[WIDTH:1];
                        lo_reg <= {mul_sum[0], lo_reg[WIDTH-1:1]};
                    end
                    // cnt_reg == 1 means this edge performs the last iteration.
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_reg <= fix_result;
                    state_reg  <= S_WRITE;
                end
                S_WRITE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy      = (state_reg != S_IDLE);
    assign Stall     = ((state_reg == S_IDLE) & Start) | Busy;
    assign HiLoEn    = (state_reg == S_WRITE);
    assign Done      = HiLoEn;
    assign DivByZero = HiLoEn & dbz_reg;
    assign HiLoWrite = result_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed bench for muldiv_sequencer (WIDTH = 32). Expected results are
// hand-computed constants; vectors whose result depends on signed handling
// carry both expectations selected by MULDIV_SIGNED_EN.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, stall, hiloen, done, dbz;
    logic [63:0] hilowrite;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .Clk       (clk),
        .Rst       (rst_n),
        .Start     (start),
        .Op        (op),
        .Signed    (sgn),
        .A         (a),
        .B         (b),
        .Busy      (busy),
        .Stall     (stall),
        .HiLoEn    (hiloen),
        .HiLoWrite (hilowrite),
        .Done      (done),
        .DivByZero (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to its HiLo write.
    //   poke_at  : nonzero -> pulse Start (with other operands) after that
    //              many edges past the accept edge; it must be ignored
    //   siw      : raise Start while in WRITE; it must be ignored
    task automatic run_op(input string tag, input logic o, input logic s,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp, input logic exp_dbz,
                          input int exp_lat, input int poke_at, input logic siw);
        int k;
        int stray;
        int watch;
        logic seen;
        @(negedge clk);
        op = o; sgn = s; a = av; b = bv; start = 1'b1;
        #1;
        check({tag, " stall_idle"}, 64'(stall), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
        k = 0;
        seen = 1'b0;
        while (k < 100 && !seen) begin
            if (poke_at != 0 && k == poke_at) begin
                start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0000_0003; op = ~o;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (hiloen) seen = 1'b1;
        end
        start = 1'b0;
        $display("op %s: op=%0d signed=%0d A=%h B=%h -> HiLo=%h dbz=%0d after %0d cycles",
                 tag, o, s, av, bv, hilowrite, dbz, k);
        check({tag, " latency"}, 64'(k), 64'(exp_lat));
        check({tag, " hilo"}, hilowrite, exp);
        check({tag, " dbz"}, 64'(dbz), 64'(exp_dbz));
        check({tag, " done"}, 64'(done), 64'd1);
        if (siw) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " hiloen_after"}, 64'(hiloen), 64'd0);
        check({tag, " busy_after"}, 64'(busy), 64'd0);
        check({tag, " hilo_hold"}, hilowrite, exp);
        stray = 0;
        watch = (poke_at != 0 || siw) ? 40 : 2;
        for (int i = 0; i < watch; i++) begin
            @(posedge clk); #1;
            if (busy || hiloen) stray++;
        end
        check({tag, " no_extra_op"}, 64'(stray), 64'd0);
    endtask

    initial begin
        int stray;

        // Reset state
        #2;
        check("rst busy", 64'(busy), 64'd0);
        check("rst hiloen", 64'(hiloen), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst dbz", 64'(dbz), 64'd0);
        check("rst hilo", hilowrite, 64'd0);
        check("rst stall0", 64'(stall), 64'd0);
        start = 1'b1;
        #1;
        check("rst stall1", 64'(stall), 64'd1);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned multiplies
        run_op("mul_ff", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 1'b0, 34, 0, 1'b0);
        run_op("mul_shift", 1'b0, 1'b0, 32'h0000_1234, 32'h0001_0000,
               64'h0000_0000_1234_0000, 1'b0, 34, 0, 1'b0);
        run_op("mul_zero", 1'b0, 1'b0, 32'h0000_0007, 32'h0000_0000,
               64'h0, 1'b0, 34, 0, 1'b0);

        // Unsigned divides
        run_op("div_100_7", 1'b1, 1'b0, 32'd100, 32'd7,
               64'h0000_0002_0000_000E, 1'b0, 34, 0, 1'b0);
        run_op("div_5_9", 1'b1, 1'b0, 32'd5, 32'd9,
               64'h0000_0005_0000_0000, 1'b0, 34, 0, 1'b0);
        run_op("div_ff_1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1,
               64'h0000_0000_FFFF_FFFF, 1'b0, 34, 0, 1'b0);

        // Divide by zero, with a Start raised during WRITE
        run_op("div0", 1'b1, 1'b0, 32'd100, 32'd0,
               64'h0000_0064_FFFF_FFFF, 1'b1, 1, 0, 1'b1);
        run_op("div0_neg", 1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0,
               64'hFFFF_FFF0_FFFF_FFFF, 1'b1, 1, 0, 1'b0);

`ifdef MULDIV_SIGNED_EN
        run_op("smul_m3_7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7,
               64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 34, 0, 1'b0);
        run_op("sdiv_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34, 0, 1'b0);
        run_op("sdiv_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000, 1'b0, 34, 0, 1'b0);
        run_op("smul_m1_2", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 34, 0, 1'b0);
`else
        run_op("smul_m3_7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7,
               64'h0000_0006_FFFF_FFEB, 1'b0, 34, 0, 1'b0);
        run_op("sdiv_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,
               64'h0000_0001_7FFF_FFFC, 1'b0, 34, 0, 1'b0);
        run_op("sdiv_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h8000_0000_0000_0000, 1'b0, 34, 0, 1'b0);
        run_op("smul_m1_2", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2,
               64'h0000_0001_FFFF_FFFE, 1'b0, 34, 0, 1'b0);
`endif

        // Start pulsed at RUN iteration 5 must be ignored
        run_op("hazard", 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0010,
               64'h0000_0000_0000_0100, 1'b0, 34, 5, 1'b0);

        // Reset at RUN iteration 10 aborts with no write
        @(negedge clk);
        op = 1'b0; sgn = 1'b0; a = 32'd5; b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hiloen", 64'(hiloen), 64'd0);
        check("abort hilo", hilowrite, 64'd0);
        check("abort stall0", 64'(stall), 64'd0);
        start = 1'b1;
        #1;
        check("abort stall1", 64'(stall), 64'd1);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (hiloen || busy) stray++;
        end
        $display("abort: reset mid-RUN, stray activity cycles=%0d", stray);
        check("abort no_write", 64'(stray), 64'd0);

        // First Start after reset release is accepted
        run_op("post_rst", 1'b0, 1'b0, 32'd3, 32'd5,
               64'h0000_0000_0000_000F, 1'b0, 34, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
